// File: rtl/stat_counter_pkg.sv
// rtl/stat_counter_pkg.sv - shared types and constants for the statistics counter table
package stat_counter_pkg;

    // Command bits; an add and a read to the same counter share one pipeline slot
    typedef enum logic [2:0] {
        CMD_NONE  = 3'b000,
        CMD_ADD   = 3'b001,
        CMD_PEEK  = 3'b010,
        CMD_RDCLR = 3'b100
    } cmd_t;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int NUM_STAGES = 6;
    localparam int RD_STAGE   = 2;

    function automatic logic cmd_has(input logic [2:0] cmd, input cmd_t bit_mask);
        return |(cmd & bit_mask);
    endfunction

endpackage

// File: rtl/stat_cnt_sdpram.sv
// rtl/stat_cnt_sdpram.sv - simple dual-port counter RAM, registered write, 2-cycle read
module stat_cnt_sdpram #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [0:(2**ADDR_WIDTH)-1];
    logic [DATA_WIDTH-1:0] r_rd_q1;

    // Write port; a read of the same address on the same edge returns the old word
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Array read plus output register
    always_ff @(posedge i_clk) begin
        r_rd_q1 <= r_mem[i_raddr];
        o_rdata <= r_rd_q1;
    end

endmodule

// File: rtl/stat_counter_table_v2.sv
// rtl/stat_counter_table_v2.sv - statistics counter table with forwarding RMW pipeline
module stat_counter_table_v2
    import stat_counter_pkg::*;
#(
    parameter int INDEX_WIDTH   = 10,
    parameter int COUNTER_WIDTH = 64,
    parameter int ADD_WIDTH     = 16,
    parameter bit SATURATE      = 1'b0
) (
    input  logic                     i_clk,
    input  logic                     i_rstn,
    output logic                     o_init_done,
    input  logic                     i_add_valid,
    input  logic [INDEX_WIDTH-1:0]   i_add_index,
    input  logic [ADD_WIDTH-1:0]     i_add_value,
    input  logic                     i_rdreq_valid,
    output logic                     o_rdreq_ready,
    input  logic [INDEX_WIDTH-1:0]   i_rdreq_index,
    input  logic                     i_rdreq_clear,
    input  logic                     i_clr_all,
    output logic                     o_rdack_valid,
    output logic [COUNTER_WIDTH-1:0] o_rdack_value,
    output logic                     o_ovf_valid,
    output logic [INDEX_WIDTH-1:0]   o_ovf_index
);

    localparam int IW         = INDEX_WIDTH;
    localparam int CW         = COUNTER_WIDTH;
    localparam int AW         = ADD_WIDTH;
    localparam int CALC_STAGE = NUM_STAGES - 2;

    state_t        r_state, w_state_nxt;
    logic [IW-1:0] r_init_cnt;

    logic [2:0]    r_st_cmd [0:CALC_STAGE];
    logic [IW-1:0] r_st_idx [0:CALC_STAGE];
    logic [AW-1:0] r_st_add [0:CALC_STAGE];

    logic [2:0]    r_wb_cmd;
    logic [IW-1:0] r_wb_idx;
    logic [CW-1:0] r_wb_val;
    logic [CW-1:0] r_wb_ack;
    logic          r_wb_ovf;
    logic          r_h1_valid, r_h2_valid;
    logic [IW-1:0] r_h1_idx, r_h2_idx;
    logic [CW-1:0] r_h1_val, r_h2_val;

    logic          w_run, w_add_go, w_rd_go, w_busy;
    logic [2:0]    w_ins_cmd;
    logic [IW-1:0] w_ins_idx;
    logic [AW-1:0] w_ins_add;
    logic [CW-1:0] w_base, w_new, w_ram_rdata, w_ram_wdata;
    logic [CW:0]   w_sum;
    logic          w_ram_we;
    logic [IW-1:0] w_ram_waddr;

    // Builds the stage-0 command: add first, then the read sees the added value
    function automatic logic [2:0] insert_cmd(input logic add_go, input logic rd_go,
                                              input logic rd_clear);
        logic [2:0] cmd;
        cmd = CMD_NONE;
        if (add_go) cmd = cmd | CMD_ADD;
        if (rd_go)  cmd = cmd | (rd_clear ? CMD_RDCLR : CMD_PEEK);
        return cmd;
    endfunction

    assign w_run         = (r_state == RUN);
    assign w_add_go      = w_run && i_add_valid;
    assign o_rdreq_ready = w_run && !(w_add_go && (i_add_index != i_rdreq_index));
    assign w_rd_go       = i_rdreq_valid && o_rdreq_ready;
    assign w_ins_cmd     = insert_cmd(w_add_go, w_rd_go, i_rdreq_clear);
    assign w_ins_idx     = w_add_go ? i_add_index : i_rdreq_index;
    assign w_ins_add     = w_add_go ? i_add_value : '0;
    assign o_init_done   = w_run;

    // FSM state register
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) r_state <= INIT;
        else         r_state <= w_state_nxt;
    end

    // FSM next state: sweep, run, and drain before a clear-all sweep
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            INIT:    if (r_init_cnt == '1) w_state_nxt = RUN;
            RUN:     if (i_clr_all)        w_state_nxt = DRAIN;
            DRAIN:   if (!w_busy)          w_state_nxt = INIT;
            default: w_state_nxt = INIT;
        endcase
    end

    // Sweep address; parked at zero outside INIT so each sweep starts at entry 0
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn)               r_init_cnt <= '0;
        else if (r_state == INIT)  r_init_cnt <= r_init_cnt + IW'(1);
        else                       r_init_cnt <= '0;
    end

    // Pipeline occupancy, used to hold off the clear-all sweep
    always_comb begin
        w_busy = (r_wb_cmd != CMD_NONE);
        for (int k = 0; k <= CALC_STAGE; k++) begin
            if (r_st_cmd[k] != CMD_NONE) w_busy = 1'b1;
        end
    end

    // Stage registers 0..CALC_STAGE
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            for (int k = 0; k <= CALC_STAGE; k++) begin
                r_st_cmd[k] <= CMD_NONE;
                r_st_idx[k] <= '0;
                r_st_add[k] <= '0;
            end
        end else begin
            r_st_cmd[0] <= w_ins_cmd;
            r_st_idx[0] <= w_ins_idx;
            r_st_add[0] <= w_ins_add;
            for (int k = 1; k <= CALC_STAGE; k++) begin
                r_st_cmd[k] <= r_st_cmd[k-1];
                r_st_idx[k] <= r_st_idx[k-1];
                r_st_add[k] <= r_st_add[k-1];
            end
        end
    end

    // Base value: the RAM word misses the last three writes, so the newest matching write wins
    always_comb begin
        w_base = w_ram_rdata;
        if (r_h2_valid && (r_h2_idx == r_st_idx[CALC_STAGE])) w_base = r_h2_val;
        if (r_h1_valid && (r_h1_idx == r_st_idx[CALC_STAGE])) w_base = r_h1_val;
        if ((r_wb_cmd != CMD_NONE) && (r_wb_idx == r_st_idx[CALC_STAGE])) w_base = r_wb_val;
        w_sum = {1'b0, w_base} + {{(CW + 1 - AW){1'b0}}, r_st_add[CALC_STAGE]};
        w_new = (SATURATE && w_sum[CW]) ? {CW{1'b1}} : w_sum[CW-1:0];
    end

    // Write stage plus the two-deep write history used for forwarding
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_wb_cmd   <= CMD_NONE;
            r_wb_idx   <= '0;
            r_wb_val   <= '0;
            r_wb_ack   <= '0;
            r_wb_ovf   <= 1'b0;
            r_h1_valid <= 1'b0;
            r_h1_idx   <= '0;
            r_h1_val   <= '0;
            r_h2_valid <= 1'b0;
            r_h2_idx   <= '0;
            r_h2_val   <= '0;
        end else begin
            r_wb_cmd   <= r_st_cmd[CALC_STAGE];
            r_wb_idx   <= r_st_idx[CALC_STAGE];
            r_wb_ack   <= w_new;
            r_wb_val   <= cmd_has(r_st_cmd[CALC_STAGE], CMD_RDCLR) ? '0 : w_new;
            r_wb_ovf   <= cmd_has(r_st_cmd[CALC_STAGE], CMD_ADD) && w_sum[CW];
            r_h1_valid <= (r_wb_cmd != CMD_NONE);
            r_h1_idx   <= r_wb_idx;
            r_h1_val   <= r_wb_val;
            r_h2_valid <= r_h1_valid;
            r_h2_idx   <= r_h1_idx;
            r_h2_val   <= r_h1_val;
        end
    end

    // Read acknowledge and overflow report, issued together with the RAM write
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_rdack_valid <= 1'b0;
            o_rdack_value <= '0;
            o_ovf_valid   <= 1'b0;
            o_ovf_index   <= '0;
        end else begin
            o_rdack_valid <= cmd_has(r_wb_cmd, CMD_PEEK) || cmd_has(r_wb_cmd, CMD_RDCLR);
            if (cmd_has(r_wb_cmd, CMD_PEEK) || cmd_has(r_wb_cmd, CMD_RDCLR)) begin
                o_rdack_value <= r_wb_ack;
            end
            o_ovf_valid <= r_wb_ovf;
            if (r_wb_ovf) o_ovf_index <= r_wb_idx;
        end
    end

    assign w_ram_we    = (r_state == INIT) || (r_wb_cmd != CMD_NONE);
    assign w_ram_waddr = (r_state == INIT) ? r_init_cnt : r_wb_idx;
    assign w_ram_wdata = (r_state == INIT) ? '0 : r_wb_val;

    stat_cnt_sdpram #(
        .ADDR_WIDTH (IW),
        .DATA_WIDTH (CW)
    ) u_ram (
        .i_clk   (i_clk),
        .i_we    (w_ram_we),
        .i_waddr (w_ram_waddr),
        .i_wdata (w_ram_wdata),
        .i_raddr (r_st_idx[RD_STAGE]),
        .o_rdata (w_ram_rdata)
    );

endmodule

// File: tb/tb_stat_counter_table_v2.sv
// tb/tb_stat_counter_table_v2.sv - directed vector bench for stat_counter_table_v2
module tb_stat_counter_table_v2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn;
    logic        add_valid, rd_valid, rd_clear, clr_all;
    logic [9:0]  add_index, rd_index;
    logic [15:0] add_value;
    logic        init_done, rd_ready, ack_valid, ovf_valid;
    logic [63:0] ack_value;
    logic [9:0]  ovf_index;

    logic        s_add_valid, s_rd_valid, s_rd_clear, s_clr_all;
    logic [3:0]  s_add_index, s_rd_index;
    logic [7:0]  s_add_value;
    logic        sat_init_done, sat_ready, sat_ack_valid, sat_ovf_valid;
    logic [7:0]  sat_ack_value;
    logic [3:0]  sat_ovf_index;
    logic        wrp_init_done, wrp_ready, wrp_ack_valid, wrp_ovf_valid;
    logic [7:0]  wrp_ack_value;
    logic [3:0]  wrp_ovf_index;

    stat_counter_table_v2 #(.INDEX_WIDTH(10), .COUNTER_WIDTH(64), .ADD_WIDTH(16), .SATURATE(1'b0)) u_dut (
        .i_clk(clk), .i_rstn(rstn), .o_init_done(init_done),
        .i_add_valid(add_valid), .i_add_index(add_index), .i_add_value(add_value),
        .i_rdreq_valid(rd_valid), .o_rdreq_ready(rd_ready), .i_rdreq_index(rd_index),
        .i_rdreq_clear(rd_clear), .i_clr_all(clr_all),
        .o_rdack_valid(ack_valid), .o_rdack_value(ack_value),
        .o_ovf_valid(ovf_valid), .o_ovf_index(ovf_index));

    stat_counter_table_v2 #(.INDEX_WIDTH(4), .COUNTER_WIDTH(8), .ADD_WIDTH(8), .SATURATE(1'b1)) u_sat (
        .i_clk(clk), .i_rstn(rstn), .o_init_done(sat_init_done),
        .i_add_valid(s_add_valid), .i_add_index(s_add_index), .i_add_value(s_add_value),
        .i_rdreq_valid(s_rd_valid), .o_rdreq_ready(sat_ready), .i_rdreq_index(s_rd_index),
        .i_rdreq_clear(s_rd_clear), .i_clr_all(s_clr_all),
        .o_rdack_valid(sat_ack_valid), .o_rdack_value(sat_ack_value),
        .o_ovf_valid(sat_ovf_valid), .o_ovf_index(sat_ovf_index));

    stat_counter_table_v2 #(.INDEX_WIDTH(4), .COUNTER_WIDTH(8), .ADD_WIDTH(8), .SATURATE(1'b0)) u_wrp (
        .i_clk(clk), .i_rstn(rstn), .o_init_done(wrp_init_done),
        .i_add_valid(s_add_valid), .i_add_index(s_add_index), .i_add_value(s_add_value),
        .i_rdreq_valid(s_rd_valid), .o_rdreq_ready(wrp_ready), .i_rdreq_index(s_rd_index),
        .i_rdreq_clear(s_rd_clear), .i_clr_all(s_clr_all),
        .o_rdack_valid(wrp_ack_valid), .o_rdack_value(wrp_ack_value),
        .o_ovf_valid(wrp_ovf_valid), .o_ovf_index(wrp_ovf_index));

    typedef struct {
        logic        av;
        logic [9:0]  ai;
        logic [15:0] ad;
        logic        rv;
        logic [9:0]  ri;
        logic        rc;
        logic        rdy;
        logic [63:0] ack;
    } vec_t;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          spurious = 0;
    int          main_ovf = 0, sat_ovf = 0, wrp_ovf = 0;
    logic [3:0]  sat_ovf_idx = '0, wrp_ovf_idx = '0;
    logic [63:0] exp_val [$];
    int          exp_edge [$];
    logic [63:0] e_v;
    int          e_e;
    vec_t        vecs [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (ack_valid) begin
            if (exp_val.size() == 0) begin
                spurious++;
            end else begin
                e_v = exp_val.pop_front();
                e_e = exp_edge.pop_front();
                check("rdack value", ack_value, e_v);
                check("rdack latency", 64'(cyc), 64'(e_e));
            end
        end
        if (ovf_valid) main_ovf++;
        if (sat_ovf_valid) begin sat_ovf++; sat_ovf_idx = sat_ovf_index; end
        if (wrp_ovf_valid) begin wrp_ovf++; wrp_ovf_idx = wrp_ovf_index; end
    end

    function automatic vec_t vb(input int ai, input int ad, input bit rv, input int ri,
                                input bit rc, input bit rdy, input longint ack);
        vec_t v;
        v.av = 1'b1; v.ai = 10'(ai); v.ad = 16'(ad);
        v.rv = rv;   v.ri = 10'(ri); v.rc = rc;
        v.rdy = rdy; v.ack = 64'(ack);
        return v;
    endfunction

    function automatic vec_t va(input int ai, input int ad);
        return vb(ai, ad, 1'b0, ai, 1'b0, 1'b1, 0);
    endfunction

    function automatic vec_t vr(input int ri, input bit rc, input longint ack);
        vec_t v;
        v = vb(0, 0, 1'b1, ri, rc, 1'b1, ack);
        v.av = 1'b0;
        return v;
    endfunction

    function automatic vec_t vi();
        vec_t v;
        v = vb(0, 0, 1'b0, 0, 1'b0, 1'b1, 0);
        v.av = 1'b0;
        return v;
    endfunction

    task automatic idle();
        add_valid = 0; add_index = '0; add_value = '0;
        rd_valid = 0; rd_index = '0; rd_clear = 0; clr_all = 0;
    endtask

    task automatic apply(input vec_t v, input string tag);
        add_valid = v.av; add_index = v.ai; add_value = v.ad;
        rd_valid = v.rv; rd_index = v.ri; rd_clear = v.rc;
        @(negedge clk);
        check({tag, " ready"}, 64'(rd_ready), 64'(v.rdy));
        if (v.rv && v.rdy) begin
            exp_val.push_back(v.ack);
            exp_edge.push_back(cyc + 7);
        end
        @(posedge clk); #1;
    endtask

    task automatic drain(input string tag);
        idle();
        repeat (12) @(posedge clk);
        #1;
        check({tag, " pending rdacks"}, 64'(exp_val.size()), 0);
    endtask

    task automatic wait_init(input string tag);
        bit seen = 1'b0;
        for (int k = 0; k < 3000 && !seen; k++) begin
            @(negedge clk);
            if (init_done) seen = 1'b1;
        end
        check({tag, " init_done seen"}, 64'(seen), 1);
        @(posedge clk); #1;
    endtask

    task automatic s_add(input int ai, input int ad);
        s_add_valid = 1; s_add_index = 4'(ai); s_add_value = 8'(ad);
        @(posedge clk); #1;
        s_add_valid = 0;
    endtask

    task automatic s_read(input int ri, input bit rc, input int e_sat, input int e_wrp, input string tag);
        int  start;
        bit  seen = 1'b0;
        s_rd_valid = 1; s_rd_index = 4'(ri); s_rd_clear = rc;
        @(negedge clk);
        check({tag, " ready"}, 64'(sat_ready & wrp_ready), 1);
        start = cyc + 1;
        @(posedge clk); #1;
        s_rd_valid = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (sat_ack_valid) begin
                seen = 1'b1;
                check({tag, " sat value"}, 64'(sat_ack_value), 64'(e_sat));
                check({tag, " wrap value"}, 64'(wrp_ack_value), 64'(e_wrp));
                check({tag, " wrap ack aligned"}, 64'(wrp_ack_valid), 1);
                check({tag, " latency"}, 64'(cyc - start), 6);
            end
        end
        check({tag, " rdack seen"}, 64'(seen), 1);
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rstn = 0;
        idle();
        s_add_valid = 0; s_add_index = '0; s_add_value = '0;
        s_rd_valid = 0; s_rd_index = '0; s_rd_clear = 0; s_clr_all = 0;
        @(negedge clk);
        check("reset init_done", 64'(init_done), 0);
        check("reset rdreq_ready", 64'(rd_ready), 0);
        check("reset rdack_valid", 64'(ack_valid), 0);
        check("reset ovf_valid", 64'(ovf_valid), 0);
        @(posedge clk); #1;
        rstn = 1;

        // Test 1: sweep timing, then every counter reads zero
        repeat (1023) @(posedge clk);
        @(negedge clk);
        check("init_done before sweep end", 64'(init_done), 0);
        check("ready during INIT", 64'(rd_ready), 0);
        @(posedge clk);
        @(negedge clk);
        check("init_done after sweep", 64'(init_done), 1);
        check("small duts init_done", 64'(sat_init_done & wrp_init_done), 1);
        @(posedge clk); #1;
        for (int i = 0; i < 1024; i++) apply(vr(i, 1'b0, 0), "t1 peek");
        drain("t1");

        // Test 4: saturate versus wrap on 8-bit counters
        s_add(1, 200);
        s_add(1, 100);
        s_read(1, 1'b0, 255, 44, "t4 peek");
        check("t4 sat ovf count", 64'(sat_ovf), 1);
        check("t4 sat ovf index", 64'(sat_ovf_idx), 1);
        check("t4 wrap ovf count", 64'(wrp_ovf), 1);
        check("t4 wrap ovf index", 64'(wrp_ovf_idx), 1);
        s_add(1, 1);
        s_read(1, 1'b0, 255, 45, "t4 peek2");
        check("t4 sat ovf count 2", 64'(sat_ovf), 2);
        check("t4 wrap ovf count 2", 64'(wrp_ovf), 1);
        s_read(1, 1'b1, 255, 45, "t4 rdclr");
        s_read(1, 1'b0, 0, 0, "t4 after clr");

        // Tests 2, 3, 5 and forwarding distances as a vector table
        for (int i = 0; i < 8; i++) vecs.push_back(va(5, 3));
        vecs.push_back(vr(5, 1'b0, 24));
        vecs.push_back(vr(5, 1'b0, 24));
        vecs.push_back(vb(7, 10, 1'b1, 7, 1'b1, 1'b1, 10));
        vecs.push_back(va(7, 4));
        vecs.push_back(vr(7, 1'b0, 4));
        vecs.push_back(vb(2, 1, 1'b1, 9, 1'b0, 1'b0, 0));
        vecs.push_back(vr(9, 1'b0, 0));
        vecs.push_back(vr(2, 1'b0, 1));
        vecs.push_back(vb(5, 1, 1'b1, 5, 1'b0, 1'b1, 25));
        vecs.push_back(vr(5, 1'b1, 25));
        vecs.push_back(vr(5, 1'b0, 0));
        vecs.push_back(va(3, 1));
        vecs.push_back(va(3, 1));
        vecs.push_back(vi());
        vecs.push_back(va(3, 1));
        vecs.push_back(vi());
        vecs.push_back(vi());
        vecs.push_back(va(3, 1));
        vecs.push_back(vi());
        vecs.push_back(vi());
        vecs.push_back(vi());
        vecs.push_back(va(3, 1));
        vecs.push_back(vr(3, 1'b0, 5));
        vecs.push_back(va(8, 16'hFFFF));
        vecs.push_back(va(8, 16'hFFFF));
        vecs.push_back(vr(8, 1'b0, 131070));
        vecs.push_back(vr(7, 1'b1, 4));
        vecs.push_back(vr(7, 1'b0, 0));
        foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));
        drain("table");

        // Test 6: clear-all during add traffic
        for (int i = 0; i < 4; i++) apply(va(4, 1), "t6 add");
        add_valid = 1; add_index = 10'd4; add_value = 16'd1; clr_all = 1;
        @(posedge clk); #1;
        clr_all = 0;
        rd_valid = 1; rd_index = 10'd4; rd_clear = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check($sformatf("t6 init_done low %0d", i), 64'(init_done), 0);
            check($sformatf("t6 ready low %0d", i), 64'(rd_ready), 0);
            @(posedge clk); #1;
        end
        idle();
        wait_init("t6");
        apply(vr(4, 1'b0, 0), "t6 peek4");
        apply(vr(5, 1'b0, 0), "t6 peek5");
        apply(vr(3, 1'b0, 0), "t6 peek3");
        apply(va(5, 9), "t6 add5");
        apply(va(5, 9), "t6 add5");
        apply(vr(5, 1'b0, 18), "t6 peek5b");
        drain("t6");

        // Reset in the middle of a read burst
        for (int i = 0; i < 3; i++) begin
            rd_valid = 1; rd_index = 10'd5; rd_clear = 0;
            @(posedge clk); #1;
        end
        rstn = 0;
        idle();
        @(negedge clk);
        check("rst mid init_done", 64'(init_done), 0);
        check("rst mid rdack_valid", 64'(ack_valid), 0);
        @(posedge clk);
        @(posedge clk); #1;
        rstn = 1;
        repeat (12) @(posedge clk);
        #1;
        check("rst mid no rdack", 64'(spurious), 0);
        wait_init("rst");
        apply(vr(5, 1'b0, 0), "rst peek5");
        drain("rst");

        check("spurious rdack total", 64'(spurious), 0);
        check("main ovf never", 64'(main_ovf), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
